// File: rtl/dmem_if.sv
// Request/response bundle for the byte-addressed data memory bank.
// The master issues loads/stores; the slave returns load data and fault pulses.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  st_op;
    logic [2:0]  ld_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;
    logic        init_done;

    modport master (
        output req_valid, st_op, ld_op, addr, wdata,
        input  req_ready, rdata, rvalid, misalign, init_done
    );

    modport slave (
        input  req_valid, st_op, ld_op, addr, wdata,
        output req_ready, rdata, rvalid, misalign, init_done
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-addressed data memory built from four byte-lane RAMs with registered read,
// supporting sw/sh/sb stores, lw/lh/lhu/lb/lbu loads and an optional zero-fill sweep.
module dmem_bank #(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter bit INIT_ZERO  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    dmem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WORDS = DEPTH / 4;
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic               req_ready_q, req_ready_d;
    logic               init_done_q, init_done_d;
    logic               rvalid_q, rvalid_d;
    logic               misalign_q, misalign_d;
    logic [1:0]         ld_sz_q, ld_sz_d;
    logic               ld_sgn_q, ld_sgn_d;
    logic [1:0]         ld_off_q, ld_off_d;
    logic               ld_bad_q, ld_bad_d;
    logic [31:0]        hold_q, hold_d;

    // Request decode
    logic               accept;
    logic               st_act, ld_act, ld_sgn;
    logic [1:0]         st_sz, ld_sz;
    logic               st_ok, ld_ok, bad;
    logic [1:0]         off;
    logic [IDX_W-1:0]   idx;

    // RAM port controls
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         wr_en;
    logic [3:0][7:0]    wr_byte;
    logic               rd_en;
    logic [31:0]        rd_bytes;
    logic [31:0]        ld_result;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[31:ADDR_W];

    assign off    = bus.addr[1:0];
    assign idx    = bus.addr[ADDR_W-1:2];
    assign accept = bus.req_valid && req_ready_q;

    // Size codes: 0 = byte, 1 = half, 2 = word
    always_comb begin
        st_act = 1'b1;
        st_sz  = 2'd0;
        case (bus.st_op)
            2'b01:   st_sz = 2'd2;
            2'b10:   st_sz = 2'd1;
            2'b11:   st_sz = 2'd0;
            default: st_act = 1'b0;
        endcase

        ld_act = 1'b1;
        ld_sz  = 2'd0;
        ld_sgn = 1'b0;
        case (bus.ld_op)
            3'b001:  ld_sz = 2'd2;
            3'b010:  begin ld_sz = 2'd1; ld_sgn = 1'b1; end
            3'b011:  ld_sz = 2'd1;
            3'b100:  begin ld_sz = 2'd0; ld_sgn = 1'b1; end
            3'b101:  ld_sz = 2'd0;
            default: ld_act = 1'b0;
        endcase

        st_ok = (st_sz == 2'd2) ? (off == 2'b00) : (st_sz == 2'd1) ? !off[0] : 1'b1;
        ld_ok = (ld_sz == 2'd2) ? (off == 2'b00) : (ld_sz == 2'd1) ? !off[0] : 1'b1;
        bad   = (st_act && !st_ok) || (ld_act && !ld_ok);
    end

    // Store lane steering; the sweep owns the write port while in INIT
    always_comb begin
        int n;
        int o;
        wr_idx  = idx;
        wr_en   = 4'b0000;
        wr_byte = '0;
        n       = 1 << st_sz;
        o       = int'(off);
        if (state_q == ST_INIT && INIT_ZERO != 1'b0) begin
            wr_idx = sweep_q;
            wr_en  = 4'b1111;
        end else if (accept && st_act && !bad) begin
            for (int l = 0; l < 4; l++) begin
                if (l >= o && l < o + n) begin
                    wr_en[l] = 1'b1;
                    if (BIG_ENDIAN != 1'b0)
                        wr_byte[l] = bus.wdata[8*(o+n-1-l) +: 8];
                    else
                        wr_byte[l] = bus.wdata[8*(l-o) +: 8];
                end
            end
        end
    end

    assign rd_en = accept && ld_act;

    // Read and write share one edge, so a combined request sees pre-store data
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en[gi])
                    lane_mem[wr_idx] <= wr_byte[gi];
                if (rd_en)
                    rd_q <= lane_mem[idx];
            end

            assign rd_bytes[8*gi +: 8] = rd_q;
        end
    endgenerate

    // Field extraction and extension from the registered lane bytes
    always_comb begin
        int n;
        int o;
        logic [1:0]  lane;
        logic [31:0] field;
        field = '0;
        lane  = 2'd0;
        n     = 1 << ld_sz_q;
        o     = int'(ld_off_q);
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                lane = 2'(o + k);
                if (BIG_ENDIAN != 1'b0)
                    field = {field[23:0], rd_bytes[8*lane +: 8]};
                else
                    field[8*k +: 8] = rd_bytes[8*lane +: 8];
            end
        end
        case (ld_sz_q)
            2'd0:    ld_result = ld_sgn_q ? {{24{field[7]}}, field[7:0]}
                                          : {24'd0, field[7:0]};
            2'd1:    ld_result = ld_sgn_q ? {{16{field[15]}}, field[15:0]}
                                          : {16'd0, field[15:0]};
            default: ld_result = field;
        endcase
        if (ld_bad_q)
            ld_result = '0;
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                if (INIT_ZERO == 1'b0) begin
                    state_d = ST_READY;
                end else begin
                    sweep_d = sweep_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (sweep_q == {IDX_W{1'b1}})
                        state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase

        req_ready_d = (state_d == ST_READY);
        init_done_d = (state_d == ST_READY);
        rvalid_d    = accept && ld_act;
        misalign_d  = accept && bad;

        ld_sz_d  = rvalid_d ? ld_sz  : ld_sz_q;
        ld_sgn_d = rvalid_d ? ld_sgn : ld_sgn_q;
        ld_off_d = rvalid_d ? off    : ld_off_q;
        ld_bad_d = rvalid_d ? bad    : ld_bad_q;
        hold_d   = rvalid_q ? ld_result : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rvalid_q    <= 1'b0;
            misalign_q  <= 1'b0;
            ld_sz_q     <= 2'd0;
            ld_sgn_q    <= 1'b0;
            ld_off_q    <= 2'd0;
            ld_bad_q    <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            rvalid_q    <= rvalid_d;
            misalign_q  <= misalign_d;
            ld_sz_q     <= ld_sz_d;
            ld_sgn_q    <= ld_sgn_d;
            ld_off_q    <= ld_off_d;
            ld_bad_q    <= ld_bad_d;
            hold_q      <= hold_d;
        end
    end

    // rdata shows the fresh result during the pulse and the held copy otherwise
    assign bus.rdata     = rvalid_q ? ld_result : hold_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.misalign  = misalign_q;
    assign bus.req_ready = req_ready_q;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: a big-endian swept instance and a little-endian
// unswept instance, with load results checked through an expected-data queue.
module tb_dmem_bank;
    localparam logic [1:0] SW = 2'b01, SH = 2'b10, SB = 2'b11;
    localparam logic [2:0] LW = 3'b001, LH = 3'b010, LHU = 3'b011, LB = 3'b100, LBU = 3'b101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus_be ();
    dmem_if bus_le ();

    dmem_bank #(.ADDR_W(10), .BIG_ENDIAN(1'b1), .INIT_ZERO(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .bus(bus_be.slave)
    );
    dmem_bank #(.ADDR_W(10), .BIG_ENDIAN(1'b0), .INIT_ZERO(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .bus(bus_le.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input bit le, input logic v, input logic [1:0] st,
                           input logic [2:0] ld, input logic [31:0] a, input logic [31:0] wd);
        if (le) begin
            bus_le.req_valid = v; bus_le.st_op = st; bus_le.ld_op = ld;
            bus_le.addr = a; bus_le.wdata = wd;
        end else begin
            bus_be.req_valid = v; bus_be.st_op = st; bus_be.ld_op = ld;
            bus_be.addr = a; bus_be.wdata = wd;
        end
    endtask

    task automatic get_bus(input bit le, output logic rdy, output logic rv,
                           output logic mis, output logic [31:0] rd, output logic idn);
        if (le) begin
            rdy = bus_le.req_ready; rv = bus_le.rvalid; mis = bus_le.misalign;
            rd = bus_le.rdata; idn = bus_le.init_done;
        end else begin
            rdy = bus_be.req_ready; rv = bus_be.rvalid; mis = bus_be.misalign;
            rd = bus_be.rdata; idn = bus_be.init_done;
        end
    endtask

    // One request, issued at a falling edge and observed at the next falling edge
    task automatic req(input bit le, input logic [1:0] st, input logic [2:0] ld,
                       input logic [31:0] a, input logic [31:0] wd, input bit exp_rv,
                       input logic [31:0] exp_rd, input bit exp_mis, input string tag);
        logic rdy, rv, mis, idn;
        logic [31:0] rd, e;
        if (exp_rv) exp_q.push_back(exp_rd);
        get_bus(le, rdy, rv, mis, rd, idn);
        check({tag, " req_ready"}, 32'(rdy), 32'd1);
        set_bus(le, 1'b1, st, ld, a, wd);
        @(posedge clk);
        @(negedge clk);
        set_bus(le, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        get_bus(le, rdy, rv, mis, rd, idn);
        check({tag, " rvalid"}, 32'(rv), 32'(exp_rv));
        check({tag, " misalign"}, 32'(mis), 32'(exp_mis));
        if (exp_rv) begin
            e = exp_q.pop_front();
            if (rv) check({tag, " rdata"}, rd, e);
        end
        $display("req %s: st=%b ld=%b addr=%h wdata=%h -> rvalid=%b rdata=%h misalign=%b",
                 tag, st, ld, a, wd, rv, rd, mis);
    endtask

    initial begin
        logic rdy, rv, mis, idn;
        logic [31:0] rd;
        int cnt, pulses;

        set_bus(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        set_bus(1'b1, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            get_bus(s[0], rdy, rv, mis, rd, idn);
            check("reset req_ready", 32'(rdy), 32'd0);
            check("reset rvalid", 32'(rv), 32'd0);
            check("reset misalign", 32'(mis), 32'd0);
            check("reset rdata", rd, 32'd0);
            check("reset init_done", 32'(idn), 32'd0);
        end

        // Release; hold a lw on the swept instance, which must never be accepted
        rst_n = 1'b1;
        set_bus(1'b0, 1'b1, 2'b00, LW, 32'h0, 32'h0);
        pulses = 0;
        @(posedge clk);
        @(negedge clk);
        get_bus(1'b1, rdy, rv, mis, rd, idn);
        check("le ready after one edge", 32'(rdy), 32'd1);
        check("le init_done", 32'(idn), 32'd1);
        get_bus(1'b0, rdy, rv, mis, rd, idn);
        check("be ready early", 32'(rdy), 32'd0);
        for (int c = 1; c < 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            get_bus(1'b0, rdy, rv, mis, rd, idn);
            if (rv || mis || rdy) pulses++;
        end

        rst_n = 1'b0;
        #1;
        get_bus(1'b0, rdy, rv, mis, rd, idn);
        check("midsweep reset ready", 32'(rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        rdy = 1'b0;
        while (!rdy && cnt < 400) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
            get_bus(1'b0, rdy, rv, mis, rd, idn);
            if (rv || mis) pulses++;
        end
        set_bus(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        check("sweep cycles", 32'(cnt), 32'd256);
        check("pulses during init", 32'(pulses), 32'd0);
        check("be init_done", 32'(idn), 32'd1);
        $display("sweep: ready after %0d cycles, stray pulses %0d", cnt, pulses);

        // Big-endian instance
        req(1'b0, 2'b00, LW, 32'h3FC, 32'h0, 1'b1, 32'h00000000, 1'b0, "lw top zeroed");
        req(1'b0, SW, 3'b000, 32'h10, 32'h8081F2F3, 1'b0, 32'h0, 1'b0, "be sw");
        req(1'b0, 2'b00, LB,  32'h10, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, "be lb");
        req(1'b0, 2'b00, LBU, 32'h10, 32'h0, 1'b1, 32'h00000080, 1'b0, "be lbu");
        req(1'b0, 2'b00, LH,  32'h12, 32'h0, 1'b1, 32'hFFFFF2F3, 1'b0, "be lh");
        req(1'b0, 2'b00, LHU, 32'h12, 32'h0, 1'b1, 32'h0000F2F3, 1'b0, "be lhu");
        @(posedge clk);
        @(negedge clk);
        get_bus(1'b0, rdy, rv, mis, rd, idn);
        check("hold rvalid", 32'(rv), 32'd0);
        check("hold rdata", rd, 32'h0000F2F3);
        req(1'b0, SB, 3'b000, 32'h11, 32'h0000005A, 1'b0, 32'h0, 1'b0, "be sb");
        req(1'b0, 2'b00, LW, 32'h10, 32'h0, 1'b1, 32'h805AF2F3, 1'b0, "be lw after sb");

        req(1'b0, SW, 3'b000, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0, "sw 0x20");
        req(1'b0, SW, 3'b000, 32'h22, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, "sw misaligned");
        req(1'b0, 2'b00, LW, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0, "lw 0x20 unchanged");
        req(1'b0, 2'b00, LH, 32'h13, 32'h0, 1'b1, 32'h00000000, 1'b1, "lh misaligned");
        req(1'b0, 2'b00, LW, 32'h21, 32'h0, 1'b1, 32'h00000000, 1'b1, "lw misaligned");

        req(1'b0, SW, 3'b000, 32'h40, 32'h11111111, 1'b0, 32'h0, 1'b0, "sw 0x40");
        req(1'b0, SW, LW, 32'h40, 32'hAAAAAAAA, 1'b1, 32'h11111111, 1'b0, "sw+lw rbw");
        req(1'b0, 2'b00, LW, 32'h40, 32'h0, 1'b1, 32'hAAAAAAAA, 1'b0, "lw after rbw");
        req(1'b0, 2'b00, 3'b000, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, "none op");
        get_bus(1'b0, rdy, rv, mis, rd, idn);
        check("none op rdata held", rd, 32'hAAAAAAAA);
        req(1'b0, 2'b00, LH,  32'h40, 32'h0, 1'b1, 32'hFFFFAAAA, 1'b0, "be lh neg");
        req(1'b0, 2'b00, LBU, 32'h43, 32'h0, 1'b1, 32'h000000AA, 1'b0, "be lbu top lane");

        // Little-endian instance
        req(1'b1, SW, 3'b000, 32'h10, 32'h8081F2F3, 1'b0, 32'h0, 1'b0, "le sw");
        req(1'b1, 2'b00, LW,  32'h10, 32'h0, 1'b1, 32'h8081F2F3, 1'b0, "le lw");
        req(1'b1, 2'b00, LBU, 32'h10, 32'h0, 1'b1, 32'h000000F3, 1'b0, "le lbu");
        req(1'b1, 2'b00, LH,  32'h12, 32'h0, 1'b1, 32'hFFFF8081, 1'b0, "le lh");
        req(1'b1, SW, 3'b000, 32'h14, 32'h00000000, 1'b0, 32'h0, 1'b0, "le sw zero");
        req(1'b1, SH, 3'b000, 32'h16, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, "le sh");
        req(1'b1, 2'b00, LW,  32'h14, 32'h0, 1'b1, 32'hBEEF0000, 1'b0, "le lw after sh");
        req(1'b1, 2'b00, 3'b110, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, "le ld_op 110");

        // Reset in the cycle after a load acceptance swallows the rvalid
        set_bus(1'b0, 1'b1, 2'b00, LW, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_bus(1'b0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        get_bus(1'b0, rdy, rv, mis, rd, idn);
        check("reset after accept rvalid", 32'(rv), 32'd0);
        check("reset after accept rdata", rd, 32'd0);
        check("reset after accept ready", 32'(rdy), 32'd0);
        $display("reset after accept: rvalid=%b rdata=%h", rv, rd);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
